// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory port between fetch (F) and stack (S), S priority with starvation guard.
// Optional grant counters built when MEM_ARBITER_STATS_EN is defined.
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          s_req,
  input  logic          s_we,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_wdata,
  output logic          s_ack,
  output logic [DW-1:0] s_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   f_grants,
  output logic [15:0]   s_grants
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic owner_s;
  logic [3:0] starve_cnt;
  logic grant_f, grant_s;
  always_comb begin
    grant_f = (state == IDLE) && f_req && (!s_req || starve_cnt == LIM);
    grant_s = (state == IDLE) && s_req && !grant_f;
    state_nx = (state == IDLE) ? ((grant_f || grant_s) ? ACCESS : IDLE) :
               (state == ACCESS) ? RESP : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
      owner_s <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (grant_f || grant_s) begin
        mem_addr <= grant_s ? s_addr : f_addr;
        owner_s <= grant_s;
        mem_we <= grant_s && s_we;
      end else if (state == ACCESS) mem_we <= 1'b0;
      if (grant_s) mem_wdata <= s_wdata;
      if (grant_f) starve_cnt <= '0;
      else if (grant_s) starve_cnt <= !f_req ? 4'd0 : (starve_cnt == LIM) ? starve_cnt : starve_cnt + 4'd1;
    end
  end
  assign f_ack = (state == RESP) && !owner_s;
  assign s_ack = (state == RESP) && owner_s;
  assign f_rdata = f_ack ? mem_rdata : '0;
  assign s_rdata = s_ack ? mem_rdata : '0;
`ifdef MEM_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_grants <= '0;
      s_grants <= '0;
    end else begin
      if (grant_f && f_grants != 16'hFFFF) f_grants <= f_grants + 16'd1;
      if (grant_s && s_grants != 16'hFFFF) s_grants <= s_grants + 16'd1;
    end
  end
`else
  assign f_grants = '0;
  assign s_grants = '0;
`endif
endmodule
